// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit path.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 868;   // 100 MHz / 115200
   localparam int BAUD_W           = 16;
   localparam int DATA_BITS        = 8;
   localparam int IDX_W            = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } tx_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
)(
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic bit_tick
);

   localparam logic [BAUD_W-1:0] LAST = BAUD_W'(CLKS_PER_BIT - 1);

   logic [BAUD_W-1:0] cnt_q, cnt_d;

   // Disabled or at the bit boundary, the count returns to 0.
   always_comb begin
      cnt_d = '0;
      if (enable && (cnt_q != LAST))
         cnt_d = cnt_q + BAUD_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign bit_tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_stage.sv
// 8N1 UART transmitter that pulls bytes from a synchronous FIFO (read latency 1).
module uart_tx_stage
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   input  logic       fifo_data_valid,
   output logic       fifo_rd_en,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 fetch_q, fetch_d;   // set in the second FETCH cycle
   logic                 rd_q, rd_d;
   logic                 tx_q, tx_d;
   logic                 baud_en, bit_tick;

   assign baud_en = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

   uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk      (clk),
      .rst      (rst),
      .enable   (baud_en),
      .bit_tick (bit_tick)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      fetch_d = 1'b0;
      rd_d    = 1'b0;
      case (state_q)
         ST_IDLE: if (!fifo_empty) begin
            state_d = ST_FETCH;
            rd_d    = 1'b1;
         end
         ST_FETCH: begin
            if (fifo_data_valid) begin
               shift_d = fifo_data;
               state_d = ST_START;
            end else if (fetch_q) begin
               state_d = ST_IDLE;
            end else begin
               fetch_d = 1'b1;
            end
         end
         ST_START: if (bit_tick) begin
            state_d = ST_DATA;
            idx_d   = '0;
         end
         ST_DATA: if (bit_tick) begin
            shift_d = shift_q >> 1;
            if (idx_q == IDX_W'(DATA_BITS - 1)) state_d = ST_STOP;
            else                                idx_d   = idx_q + IDX_W'(1);
         end
         ST_STOP: if (bit_tick) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Line level follows the state being entered so tx comes straight from a flop.
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         fetch_q <= 1'b0;
         rd_q    <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         fetch_q <= fetch_d;
         rd_q    <= rd_d;
         tx_q    <= tx_d;
      end
   end

   assign fifo_rd_en = rd_q;
   assign tx         = tx_q;
   assign busy       = (state_q != ST_IDLE);
   assign tx_done    = (state_q == ST_STOP) && bit_tick;

endmodule

// File: tb/tb_uart_tx_stage.sv
// Randomized bench for uart_tx_stage; the expected line is derived from frame timing arithmetic.
module tb_uart_tx_stage;

   localparam int P  = 4;            // fast instance bit period
   localparam int FL = 10*P + 3;     // frame slot: idle + 2 fetch cycles + 10 bits
   localparam int PS = 868;          // slow instance bit period

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, fifo_empty, fifo_data_valid;
   logic [7:0] fifo_data;
   logic       fifo_rd_en, tx, busy, tx_done;
   logic       s_empty, s_valid;
   logic [7:0] s_data;
   logic       s_rd, s_tx, s_busy, s_done;

   uart_tx_stage #(.CLKS_PER_BIT(P)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_data_valid(fifo_data_valid), .fifo_rd_en(fifo_rd_en), .tx(tx),
      .busy(busy), .tx_done(tx_done)
   );

   uart_tx_stage #(.CLKS_PER_BIT(PS)) dut_slow (
      .clk(clk), .rst(rst), .fifo_empty(s_empty), .fifo_data(s_data),
      .fifo_data_valid(s_valid), .fifo_rd_en(s_rd), .tx(s_tx),
      .busy(s_busy), .tx_done(s_done)
   );

   int         checks = 0, errors = 0, cyc = 0, rd_seen = 0;
   logic [7:0] q[$];
   logic [7:0] sb[$];
   logic       pend = 1'b0, withhold = 1'b0, spur_en = 1'b0;

   // Frame bit j of byte b: start, d0..d7, stop.
   function automatic logic fbit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j >= 9) return 1'b1;
      return b[j-1];
   endfunction

   // Advance one clock and play the FIFO: data/valid one cycle after an accepted read.
   task automatic step();
      @(posedge clk); #1; cyc++;
      if (pend) begin
         fifo_data = q.pop_front(); fifo_data_valid = 1'b1; pend = 1'b0;
      end else if (spur_en && !fifo_rd_en && $urandom_range(3) == 0) begin
         fifo_data = 8'($urandom); fifo_data_valid = 1'b1;
      end else begin
         fifo_data_valid = 1'b0;
      end
      if (fifo_rd_en && !withhold && q.size() > 0) pend = 1'b1;
      fifo_empty = (q.size() == 0);
   endtask

   task automatic load_sb();
      foreach (sb[j]) q.push_back(sb[j]);
      fifo_empty = (q.size() == 0);
   endtask

   // Streams sb (already loaded, DUT idle) and checks every cycle against slot arithmetic.
   task automatic run_stream(input int tail);
      int n, total, i, r;
      logic e_tx, e_rd, e_busy, e_done;
      n = sb.size(); total = n*FL + tail; rd_seen = 0;
      for (int k = 0; k < total; k++) begin
         i = k / FL; r = k % FL;
         if (i < n) begin
            e_rd = (r == 1); e_busy = (r != 0); e_done = (r == FL-1);
            e_tx = (r < 3) ? 1'b1 : fbit(sb[i], (r-3)/P);
         end else begin
            e_rd = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_tx = 1'b1;
         end
         if (fifo_rd_en === 1'b1) rd_seen++;
         checks += 4;
         if (tx !== e_tx)         begin errors++; $display("FAIL tx k=%0d got %b exp %b", k, tx, e_tx); end
         if (fifo_rd_en !== e_rd) begin errors++; $display("FAIL rd_en k=%0d got %b exp %b", k, fifo_rd_en, e_rd); end
         if (busy !== e_busy)     begin errors++; $display("FAIL busy k=%0d got %b exp %b", k, busy, e_busy); end
         if (tx_done !== e_done)  begin errors++; $display("FAIL tx_done k=%0d got %b exp %b", k, tx_done, e_done); end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      sb = '{8'($urandom)};
      load_sb();
      repeat (3) begin
         step();
         checks += 4;
         if (tx !== 1'b1)         begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
         if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
         if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en); end
         if (tx_done !== 1'b0)    begin errors++; $display("FAIL reset_tx_done got %b exp 0", tx_done); end
      end
      rst = 1'b0;
      run_stream(4);
   endtask

   task automatic test_a5();
      sb = '{8'hA5};
      load_sb();
      run_stream(6);
   endtask

   task automatic test_idle_empty();
      for (int k = 0; k < 30; k++) begin
         checks += 3;
         if (tx !== 1'b1)         begin errors++; $display("FAIL idle_tx k=%0d got %b exp 1", k, tx); end
         if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL idle_rd_en k=%0d got %b exp 0", k, fifo_rd_en); end
         if (busy !== 1'b0)       begin errors++; $display("FAIL idle_busy k=%0d got %b exp 0", k, busy); end
         step();
      end
   endtask

   task automatic test_back_to_back();
      sb = '{8'h00, 8'hFF};
      load_sb();
      run_stream(6);
      checks++;
      if (rd_seen != 2) begin errors++; $display("FAIL b2b_rd_pulses got %0d exp 2", rd_seen); end
   endtask

   task automatic test_fetch_timeout();
      logic e_rd, e_busy;
      withhold = 1'b1;
      q.push_back(8'($urandom)); fifo_empty = 1'b0;
      for (int k = 0; k < 10; k++) begin
         e_rd   = (k >= 1) && (k % 3 == 1);
         e_busy = (k >= 1) && (k % 3 != 0);
         checks += 4;
         if (fifo_rd_en !== e_rd) begin errors++; $display("FAIL to_rd_en k=%0d got %b exp %b", k, fifo_rd_en, e_rd); end
         if (busy !== e_busy)     begin errors++; $display("FAIL to_busy k=%0d got %b exp %b", k, busy, e_busy); end
         if (tx !== 1'b1)         begin errors++; $display("FAIL to_tx k=%0d got %b exp 1", k, tx); end
         if (tx_done !== 1'b0)    begin errors++; $display("FAIL to_tx_done k=%0d got %b exp 0", k, tx_done); end
         step();
      end
      rst = 1'b1; withhold = 1'b0; q.delete(); fifo_empty = 1'b1;
      step(); step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      b = 8'($urandom);
      sb = '{b};
      load_sb();
      repeat (20) step();
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
      if (tx !== b[3])   begin errors++; $display("FAIL mid_bit3 got %b exp %b", tx, b[3]); end
      rst = 1'b1;
      step();
      checks += 3;
      if (tx !== 1'b1)      begin errors++; $display("FAIL abort_tx got %b exp 1", tx); end
      if (busy !== 1'b0)    begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
      if (tx_done !== 1'b0) begin errors++; $display("FAIL abort_tx_done got %b exp 0", tx_done); end
      rst = 1'b0;
      for (int k = 0; k < 50; k++) begin
         step();
         checks += 3;
         if (tx !== 1'b1)      begin errors++; $display("FAIL post_abort_tx k=%0d got %b exp 1", k, tx); end
         if (busy !== 1'b0)    begin errors++; $display("FAIL post_abort_busy k=%0d got %b exp 0", k, busy); end
         if (tx_done !== 1'b0) begin errors++; $display("FAIL post_abort_done k=%0d got %b exp 0", k, tx_done); end
      end
   endtask

   task automatic test_random();
      spur_en = 1'b1;
      repeat (8) begin
         sb.delete();
         repeat ($urandom_range(1, 3)) sb.push_back(8'($urandom));
         repeat ($urandom_range(0, 5)) step();
         load_sb();
         run_stream($urandom_range(1, 5));
      end
      spur_en = 1'b0;
   endtask

   task automatic test_slow();
      int rdc, fall;
      logic e_tx, e_busy, e_done;
      rdc = -1; fall = -1;
      s_empty = 1'b0;
      for (int t = 0; t < 12; t++) begin
         step();
         s_valid = 1'b0;
         if (rdc >= 0 && t == rdc + 1) begin s_valid = 1'b1; s_data = 8'h55; end
         if (s_rd === 1'b1 && rdc < 0) begin rdc = t; s_empty = 1'b1; end
         if (s_tx === 1'b0) begin fall = t; break; end
      end
      s_valid = 1'b0;
      checks++;
      if (fall < 0 || fall != rdc + 2) begin
         errors++; $display("FAIL slow_start got %0d exp %0d", fall, rdc + 2);
      end else begin
         for (int j = 0; j <= 10*PS; j++) begin
            e_tx   = (j < 10*PS) ? fbit(8'h55, j / PS) : 1'b1;
            e_busy = (j < 10*PS);
            e_done = (j == 10*PS - 1);
            checks += 3;
            if (s_tx !== e_tx)     begin errors++; $display("FAIL slow_tx j=%0d got %b exp %b", j, s_tx, e_tx); end
            if (s_busy !== e_busy) begin errors++; $display("FAIL slow_busy j=%0d got %b exp %b", j, s_busy, e_busy); end
            if (s_done !== e_done) begin errors++; $display("FAIL slow_done j=%0d got %b exp %b", j, s_done, e_done); end
            step();
         end
      end
   endtask

   initial begin
      rst = 1'b1; fifo_empty = 1'b1; fifo_data = '0; fifo_data_valid = 1'b0;
      s_empty = 1'b1; s_data = '0; s_valid = 1'b0;
      test_reset();
      test_a5();
      test_idle_empty();
      test_back_to_back();
      test_fetch_timeout();
      test_reset_mid_frame();
      test_random();
      test_slow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
